egg_timer: RTL and testbench
============================

EGG_TIMER -- requirements
Module: egg_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the CLOCK_50 frequency in Hz; it sets the 1 s tick period.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single system clock, rising-edge active.
REQ-003 SHALL have port KEY[0], input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port KEY[1], input, 1 bit: SET pushbutton, active-low (pressed = 0).
REQ-005 SHALL have port KEY[2], input, 1 bit: START/STOP pushbutton, active-low.
REQ-006 SHALL have port SW, input, 8 bits: preset minutes in BCD; SW[7:4] is the tens digit and SW[3:0] the units digit.
REQ-007 SHALL have ports HEX3, HEX2, HEX1, HEX0, output, 7 bits each: minutes tens, minutes units, seconds tens and seconds units.
REQ-008 SHALL drive HEX segments active-low, with bit0=a through bit6=g.
REQ-009 SHALL have port LEDR, output, 10 bits: alarm indicators.

Function
REQ-010 SHALL hold the time as four BCD digits MM:SS, range 00:00-99:59; HEX outputs SHALL be registered decodes of these digits.
REQ-011 SHALL pass KEY[1] and KEY[2] through a 2-FF synchroniser and a falling-edge detector, producing one-cycle press pulses; the action SHALL take effect no later than 3 clocks after the press edge.
REQ-012 SHALL implement states IDLE, RUN and ALARM.
REQ-013 A SET press in IDLE or ALARM SHALL load MM=SW and SS=00, clear the alarm and go to IDLE.
REQ-014 A SET press in RUN SHALL be ignored.
REQ-015 An SW digit greater than 9 SHALL be loaded as 9.
REQ-016 A START/STOP press in IDLE with time not 00:00 SHALL go to RUN and clear the prescaler; with time 00:00 it SHALL be ignored.
REQ-017 A START/STOP press in RUN SHALL go to IDLE, holding the time (pause).
REQ-018 A START/STOP press in ALARM SHALL go to IDLE with the time at 00:00.
REQ-019 If SET and START/STOP pulses occur in the same cycle, SET SHALL take priority.
REQ-020 In RUN, a prescaler SHALL count 0..CLK_HZ-1 and issue a one-cycle tick on wrap.
REQ-021 Each tick SHALL decrement the time: SS>0 gives SS-1; SS=00 with MM>0 gives MM-1 and SS=59, with BCD borrow across digits.
REQ-022 When the time becomes 00:00, the block SHALL enter ALARM on the same tick and stop counting.
REQ-023 In IDLE and RUN, LEDR SHALL be 0.
REQ-024 In ALARM, LEDR SHALL follow REQ-029.

Reset
REQ-025 Asserting KEY[0]=0 SHALL immediately force IDLE, time 00:00, prescaler 0, synchronisers to 1 (released) and LEDR=0, at any point including mid-RUN.
REQ-026 During reset, every HEX output SHALL be 7'b1000000 (digit 0).
REQ-027 Reset release SHALL be synchronised to CLOCK_50; the first key action SHALL be accepted 2 clocks after release.

Configuration
REQ-028 Macro EGG_TIMER_ALARM_BLINK_EN SHALL select the alarm LED behaviour.
REQ-029 When defined, LEDR SHALL toggle all 10 bits together every CLK_HZ/4 clocks (2 Hz blink) in ALARM, starting at all ones. When undefined, LEDR SHALL be steady 10'h3FF in ALARM.

Structure
REQ-030 Package egg_timer_pkg SHALL hold the state enum, the BCD digit type and the 7-segment encoding constants for 0-9 plus blank.
REQ-031 Sub-module seg7_decoder (4-bit BCD in, 7-bit active-low segments out, combinational) SHALL be instantiated four times.

Verification (CLK_HZ=10)
REQ-032 Reset held with KEY[0]=0 -> all four HEX = 7'b1000000 and LEDR=0; after release the state is IDLE.
REQ-033 SW=8'h12 then SET press -> display 12:00 (HEX3=1, HEX2=2, HEX1=0, HEX0=0); SW=8'h3F then SET press -> display 39:00.
REQ-034 SW=8'h01, SET, then START/STOP -> after 10 clocks display 00:59 (borrow); after 60 ticks display 00:00, state ALARM, LEDR nonzero.
REQ-035 While RUN at 00:45, START/STOP press -> time frozen for 50 clocks; a second press resumes, and a SET press while running is ignored.
REQ-036 START/STOP press at 00:00 -> stays IDLE; KEY[0]=0 asserted mid-RUN -> 00:00 immediately, LEDR=0.
REQ-037 In ALARM with the macro defined -> LEDR toggles every 2 clocks; without it -> LEDR steady 10'h3FF; START/STOP press -> LEDR=0.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types for the egg timer: FSM states, BCD digit type and
// active-low 7-segment patterns (bit0 = a ... bit6 = g).
package egg_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank.
module seg7_decoder
    import egg_timer_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/egg_timer.sv
// MM:SS countdown egg timer with SET / START-STOP keys and alarm LEDs.
// Define EGG_TIMER_ALARM_BLINK_EN for a 2 Hz blinking alarm instead of steady LEDs.
module egg_timer
    import egg_timer_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic [9:0] LEDR
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    // Reset asserts asynchronously, releases two clocks after KEY[0] rises.
    logic rst_meta, rst_n;
    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) {rst_n, rst_meta} <= 2'b00;
        else         {rst_n, rst_meta} <= {rst_meta, 1'b1};
    end

    logic [1:0] key_meta, key_sync, key_prev;
    logic       set_p, ss_p;
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '1;
            key_sync <= '1;
            key_prev <= '1;
        end else begin
            key_meta <= KEY[2:1];
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end
    assign set_p = key_prev[0] & ~key_sync[0];
    assign ss_p  = key_prev[1] & ~key_sync[1];

    state_t          state, state_n;
    bcd_t            mt, mu, st, su, mt_n, mu_n, st_n, su_n;
    logic [PW-1:0]   presc, presc_n;
    logic            tick;

    assign tick = (state == RUN) && (presc == PW'(CLK_HZ - 1));

    always_comb begin
        state_n = state;
        {mt_n, mu_n, st_n, su_n} = {mt, mu, st, su};
        presc_n = presc;
        if (set_p && state != RUN) begin
            mt_n    = bcd_clamp(SW[7:4]);
            mu_n    = bcd_clamp(SW[3:0]);
            st_n    = 4'd0;
            su_n    = 4'd0;
            state_n = IDLE;
        end else if (ss_p) begin
            case (state)
                IDLE: if ({mt, mu, st, su} != 16'h0) begin
                    state_n = RUN;
                    presc_n = '0;
                end
                RUN:  state_n = IDLE;
                default: begin
                    state_n = IDLE;
                    {mt_n, mu_n, st_n, su_n} = 16'h0;
                end
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                // BCD borrow ripples from seconds units up to minutes tens.
                if (su != 4'd0) begin
                    su_n = su - 4'd1;
                end else if (st != 4'd0) begin
                    st_n = st - 4'd1;
                    su_n = 4'd9;
                end else if (mu != 4'd0) begin
                    mu_n = mu - 4'd1;
                    st_n = 4'd5;
                    su_n = 4'd9;
                end else begin
                    mt_n = mt - 4'd1;
                    mu_n = 4'd9;
                    st_n = 4'd5;
                    su_n = 4'd9;
                end
                if ({mt_n, mu_n, st_n, su_n} == 16'h0) state_n = ALARM;
            end else begin
                presc_n = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {mt, mu, st, su} <= 16'h0;
            presc <= '0;
        end else begin
            state <= state_n;
            {mt, mu, st, su} <= {mt_n, mu_n, st_n, su_n};
            presc <= presc_n;
        end
    end

`ifdef EGG_TIMER_ALARM_BLINK_EN
    localparam int BLINK = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BW    = (BLINK > 1) ? $clog2(BLINK) : 1;
    logic [BW-1:0] blink_cnt;
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            LEDR      <= '0;
            blink_cnt <= '0;
        end else if (state_n == ALARM) begin
            if (state != ALARM) begin
                LEDR      <= '1;
                blink_cnt <= '0;
            end else if (blink_cnt == BW'(BLINK - 1)) begin
                LEDR      <= ~LEDR;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            LEDR      <= '0;
            blink_cnt <= '0;
        end
    end
`else
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) LEDR <= '0;
        else        LEDR <= (state_n == ALARM) ? '1 : '0;
    end
`endif

    logic [6:0] seg3, seg2, seg1, seg0;
    seg7_decoder u_dec3 (.digit(mt), .seg(seg3));
    seg7_decoder u_dec2 (.digit(mu), .seg(seg2));
    seg7_decoder u_dec1 (.digit(st), .seg(seg1));
    seg7_decoder u_dec0 (.digit(su), .seg(seg0));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            {HEX3, HEX2, HEX1, HEX0} <= {4{SEG_0}};
        end else begin
            {HEX3, HEX2, HEX1, HEX0} <= {seg3, seg2, seg1, seg0};
        end
    end

endmodule

// File: tb/tb_egg_timer.sv
// Scoreboard bench for egg_timer: a seconds-count reference model predicts the
// display/LED state every clock; a monitor pops predictions and compares.
module tb_egg_timer;

    localparam int CLK_HZ = 10;
    localparam int BLINK  = CLK_HZ / 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_ALARM = 2;

    logic       clk = 1'b0;
    logic [2:0] key = 3'b111;
    logic [7:0] sw  = 8'h00;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic [9:0] ledr;

    always #5 clk = ~clk;

    egg_timer #(.CLK_HZ(CLK_HZ)) dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw),
        .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0), .LEDR(ledr)
    );

    typedef struct {
        logic [6:0] h3, h2, h1, h0;
        logic [9:0] led;
        int         id;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0, step_id = 0;
    // Model: remaining time as plain seconds, plus mode and elapsed clocks.
    int secs = 0, shown = 0, mode = M_IDLE, presc = 0, age = 0;
    logic [9:0] led = '0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic int clampd(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic cmp(input string name, input int id, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, id, act, req);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int m, s;
        m = shown / 60;
        s = shown % 60;
        e.h3 = seg(m / 10); e.h2 = seg(m % 10);
        e.h1 = seg(s / 10); e.h0 = seg(s % 10);
        e.led = led;
        e.id = step_id;
        q.push_back(e);
    endtask

    task automatic step(input bit set_p, input bit ss_p);
        int prev;
        @(posedge clk);
        step_id++;
        shown = secs;
        prev = mode;
        if (set_p && mode != M_RUN) begin
            secs = (clampd(int'(sw[7:4])) * 10 + clampd(int'(sw[3:0]))) * 60;
            mode = M_IDLE;
        end else if (ss_p) begin
            if (mode == M_IDLE) begin
                if (secs != 0) begin mode = M_RUN; presc = 0; end
            end else if (mode == M_RUN) begin
                mode = M_IDLE;
            end else begin
                mode = M_IDLE;
                secs = 0;
            end
        end else if (mode == M_RUN) begin
            presc++;
            if (presc == CLK_HZ) begin
                presc = 0;
                secs--;
                if (secs == 0) mode = M_ALARM;
            end
        end
        if (mode == M_ALARM) begin
            age = (prev != M_ALARM) ? 0 : age + 1;
`ifdef EGG_TIMER_ALARM_BLINK_EN
            led = (((age / BLINK) % 2) == 0) ? 10'h3ff : 10'h000;
`else
            led = 10'h3ff;
`endif
        end else begin
            led = '0;
        end
        push_exp();
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    // which: 1 = SET, 2 = START/STOP; the action lands on the third edge.
    task automatic press(input int which);
        @(negedge clk);
        key[which] = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(which == 1, which == 2);
        run(2);
        @(negedge clk);
        key[which] = 1'b1;
        run(3);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        key[0] = 1'b0;
        secs = 0; shown = 0; mode = M_IDLE; presc = 0; age = 0; led = '0;
        #1;
        cmp("reset_hex0_now", step_id, {3'b0, hex0}, {3'b0, seg(0)});
        cmp("reset_hex2_now", step_id, {3'b0, hex2}, {3'b0, seg(0)});
        cmp("reset_ledr_now", step_id, ledr, 10'h000);
        run(n);
        @(negedge clk);
        key[0] = 1'b1;
        run(4);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("HEX3", e.id, {3'b0, hex3}, {3'b0, e.h3});
                cmp("HEX2", e.id, {3'b0, hex2}, {3'b0, e.h2});
                cmp("HEX1", e.id, {3'b0, hex1}, {3'b0, e.h1});
                cmp("HEX0", e.id, {3'b0, hex0}, {3'b0, e.h0});
                cmp("LEDR", e.id, ledr, e.led);
            end
        end
    end

    initial begin : stimulus
        int r;
        do_reset(3);
        // Load, including a units digit above 9.
        sw = 8'h12; press(1); run(2);
        sw = 8'h3f; press(1); run(2);
        // One minute down to the alarm, then dismiss it.
        sw = 8'h01; press(1); press(2);
        run(620);
        press(2); run(3);
        // Start at 00:00 is ignored.
        press(2); run(5);
        // Pause at 00:45, resume, ignored SET while running, reset mid-run.
        sw = 8'h01; press(1); press(2);
        run(145);
        press(2); run(50);
        press(2);
        sw = 8'h05; press(1);
        run(30);
        do_reset(2);
        // Random mix of actions.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                sw = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) sw = 8'($urandom_range(0, 1));
                press(1);
            end else if (r <= 5) begin
                press(2);
            end else if (r <= 8) begin
                run($urandom_range(1, 120));
            end else begin
                do_reset(2);
            end
        end
        run(2);
        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
